// File: rtl/ap9_pkg.sv
// Shared types and constants for the AP9 load/store sequencer.
// Op encodings, FSM states, debug codes and PC increment helper.
package ap9_pkg;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'd0,
        OP_STORE  = 3'd1,
        OP_LOADN  = 3'd2,
        OP_LOADI  = 3'd3,
        OP_STOREI = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [15:0] DBG_IDLE   = 16'h0000;
    localparam logic [15:0] DBG_FETCH  = 16'h0001;
    localparam logic [15:0] DBG_MEM_RD = 16'h0002;
    localparam logic [15:0] DBG_MEM_WR = 16'h0003;
    localparam logic [15:0] DBG_DONE   = 16'h000F;

    // Two-word instructions carry an operand word at PC+1.
    function automatic logic [1:0] pc_inc(input logic [2:0] op);
        logic [1:0] inc;
        inc = 2'd1;
        case (op)
            OP_LOAD, OP_STORE, OP_LOADN: inc = 2'd2;
            default:                     inc = 2'd1;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/ap9_mem_port.sv
// RAM request/acknowledge sequencing for the AP9 LSU.
// Captures read data on the completing edge and runs the wait timeout.
module ap9_mem_port
    import ap9_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              active_i,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              req_o,
    output logic              fire_o,
    output logic              tmo_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign req_o   = active_i;
    assign fire_o  = active_i & ack_i;
    assign rdata_o = rdata_q;

    // Last allowed wait cycle without ACK ends the access.
    assign tmo_o = (TIMEOUT > 0) && active_i && !ack_i
                   && (cnt_q == CW'(TLAST));

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        rdata_d = rdata_q;
        if (!active_i || ack_i || tmo_o) begin
            cnt_d = '0;
        end
        if (fire_o) begin
            rdata_d = rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/ap9_lsu.sv
// AP9 multicycle load/store sequencer: FSM and operand latches.
// Drives the shared RAM bus through ap9_mem_port.
module ap9_lsu
    import ap9_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    input  logic              wire_start,
    input  logic [2:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_pc,
    input  logic [DATA_W-1:0] bus_rx,
    input  logic [DATA_W-1:0] bus_ry,
    output logic              wire_busy,
    output logic              wire_done,
    output logic              wire_load_we,
    output logic [DATA_W-1:0] bus_load_data,
    output logic [ADDR_W-1:0] bus_next_pc,
    output logic              wire_fault,
    output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
    output logic              wire_RW,
    output logic [DATA_W-1:0] bus_RAM_DATA_IN,
    input  logic [DATA_W-1:0] bus_RAM_DATA_OUT,
    output logic              wire_RAM_REQ,
    input  logic              wire_RAM_ACK,
    output logic [15:0]       data_debug
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] ry_q, ry_d;
    logic              fault_q, fault_d;

    logic              active;
    logic              fire;
    logic              tmo;
    logic [DATA_W-1:0] rdata;
    logic              is_load;

    assign active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD)
                    || (state_q == ST_MEM_WR);

    ap9_mem_port #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk_i    (wire_clock),
        .rst_i    (wire_reset),
        .active_i (active),
        .ack_i    (wire_RAM_ACK),
        .rdata_i  (bus_RAM_DATA_OUT),
        .req_o    (wire_RAM_REQ),
        .fire_o   (fire),
        .tmo_o    (tmo),
        .rdata_o  (rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        pc_d    = pc_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wire_start) begin
                    op_d = bus_op;
                    pc_d = bus_pc;
                    rx_d = bus_rx;
                    ry_d = bus_ry;
                    case (bus_op)
                        OP_LOAD, OP_STORE, OP_LOADN: state_d = ST_FETCH;
                        OP_LOADI:  state_d = ST_MEM_RD;
                        OP_STOREI: state_d = ST_MEM_WR;
                        default: begin
                            state_d = ST_DONE;
                            fault_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_FETCH: begin
                if (tmo) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                end else if (fire) begin
                    case (op_q)
                        OP_LOAD:  state_d = ST_MEM_RD;
                        OP_STORE: state_d = ST_MEM_WR;
                        default:  state_d = ST_DONE;
                    endcase
                end
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (tmo) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                end else if (fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wire_clock or posedge wire_reset) begin
        if (wire_reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            pc_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            fault_q <= fault_d;
        end
    end

    // The fetched operand word sits in the port's capture register.
    always_comb begin
        bus_RAM_ADDRESS = '0;
        bus_RAM_DATA_IN = '0;
        wire_RW         = 1'b0;
        data_debug      = DBG_IDLE;
        unique case (state_q)
            ST_IDLE: data_debug = DBG_IDLE;
            ST_FETCH: begin
                bus_RAM_ADDRESS = pc_q + ADDR_W'(1);
                data_debug      = DBG_FETCH;
            end
            ST_MEM_RD: begin
                bus_RAM_ADDRESS = (op_q == OP_LOAD) ? ADDR_W'(rdata)
                                                    : ADDR_W'(ry_q);
                data_debug      = DBG_MEM_RD;
            end
            ST_MEM_WR: begin
                bus_RAM_ADDRESS = (op_q == OP_STORE) ? ADDR_W'(rdata)
                                                     : ADDR_W'(rx_q);
                bus_RAM_DATA_IN = (op_q == OP_STORE) ? rx_q : ry_q;
                wire_RW         = 1'b1;
                data_debug      = DBG_MEM_WR;
            end
            ST_DONE: data_debug = DBG_DONE;
            default: data_debug = DBG_IDLE;
        endcase
    end

    assign is_load = (op_q == OP_LOAD) || (op_q == OP_LOADN)
                     || (op_q == OP_LOADI);

    assign wire_busy     = (state_q != ST_IDLE);
    assign wire_done     = (state_q == ST_DONE);
    assign wire_fault    = wire_done & fault_q;
    assign wire_load_we  = wire_done & !fault_q & is_load;
    assign bus_load_data = wire_load_we ? rdata : '0;
    assign bus_next_pc   = wire_done
        ? pc_q + ADDR_W'(fault_q ? 2'd1 : pc_inc(op_q))
        : '0;

endmodule

// File: tb/tb_ap9_lsu.sv
// Directed bench for ap9_lsu with a wait-state RAM model.
module tb_ap9_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] pc = '0, rx = '0, ry = '0;
    logic        busy, done, ld_we, fault, rw, req, ack;
    logic [15:0] ld_data, npc, addr, din, dout, dbg;

    logic [15:0] mem [0:65535];
    int          wcnt = 0;
    int          wrc = 0;
    int          ack_delay = 0;
    bit          ack_low = 1'b0;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;

    int          errors = 0;
    int          checks = 0;

    int          cyc, reqc, unstable, wr0;
    bit          seen_req, seen_wr;
    logic [15:0] first_addr, wr_addr, wr_data;
    logic        r_we, r_flt;
    logic [15:0] r_ld, r_npc;
    bit          any_busy, any_done;

    always #5 clk = ~clk;

    ap9_lsu #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .wire_clock       (clk),
        .wire_reset       (rst),
        .wire_start       (start),
        .bus_op           (op),
        .bus_pc           (pc),
        .bus_rx           (rx),
        .bus_ry           (ry),
        .wire_busy        (busy),
        .wire_done        (done),
        .wire_load_we     (ld_we),
        .bus_load_data    (ld_data),
        .bus_next_pc      (npc),
        .wire_fault       (fault),
        .bus_RAM_ADDRESS  (addr),
        .wire_RW          (rw),
        .bus_RAM_DATA_IN  (din),
        .bus_RAM_DATA_OUT (dout),
        .wire_RAM_REQ     (req),
        .wire_RAM_ACK     (ack),
        .data_debug       (dbg)
    );

    assign dout = mem[addr];
    assign ack  = !ack_low && (wcnt >= ack_delay);

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (req && ack && rw) begin
            mem[addr] <= din;
            wrc <= wrc + 1;
        end
        if (req && !ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [15:0] p,
                       input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        op = o; pc = p; rx = x; ry = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reqc = 0; unstable = 0; seen_req = 0; seen_wr = 0;
        cyc = -1; wr0 = wrc;
        r_we = 0; r_flt = 0; r_ld = 0; r_npc = 0;
        first_addr = 0; wr_addr = 0; wr_data = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (req) begin
                reqc++;
                if (!seen_req) first_addr = addr;
                seen_req = 1;
                if (rw) begin
                    if (seen_wr && (addr != wr_addr || din != wr_data))
                        unstable++;
                    wr_addr = addr;
                    wr_data = din;
                    seen_wr = 1;
                end
            end
            if (done) begin
                cyc = k;
                r_we = ld_we; r_flt = fault;
                r_ld = ld_data; r_npc = npc;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {busy, done, fault, ld_we, req, rw}, 0);
        check("rst_dbg", dbg, 16'h0000);
        check("rst_bus", {addr, din, npc, ld_data}, 0);
        rst = 1'b0;

        poke(16'h0011, 16'h0200);
        poke(16'h0200, 16'hBEEF);
        poke(16'h0000, 16'h00AA);
        poke(16'h0021, 16'h0400);

        // LOAD, ACK tied high
        run(3'd0, 16'h0010, 16'h0, 16'h0);
        check("load_cyc", cyc, 3);
        check("load_fetch", first_addr, 16'h0011);
        check("load_we", r_we, 1);
        check("load_data", r_ld, 16'hBEEF);
        check("load_npc", r_npc, 16'h0012);
        check("load_flt", r_flt, 0);

        // STORE through fetched address
        run(3'd1, 16'h0020, 16'h5555, 16'h0);
        check("store_cyc", cyc, 3);
        check("store_mem", mem[16'h0400], 16'h5555);
        check("store_npc", r_npc, 16'h0022);
        check("store_we", r_we, 0);

        // LOADI via Ry pointer
        run(3'd3, 16'h0030, 16'h0, 16'h0200);
        check("loadi_cyc", cyc, 2);
        check("loadi_data", r_ld, 16'hBEEF);
        check("loadi_npc", r_npc, 16'h0031);

        // STOREI with two ACK wait cycles
        ack_delay = 2;
        run(3'd4, 16'h0040, 16'h0300, 16'h1234);
        ack_delay = 0;
        check("storei_cyc", cyc, 4);
        check("storei_wrs", wrc - wr0, 1);
        check("storei_addr", wr_addr, 16'h0300);
        check("storei_data", mem[16'h0300], 16'h1234);
        check("storei_stable", unstable, 0);
        check("storei_npc", r_npc, 16'h0041);

        // LOADN wrapping at top of PC space
        run(3'd2, 16'hFFFF, 16'h0, 16'h0);
        check("loadn_cyc", cyc, 2);
        check("loadn_fetch", first_addr, 16'h0000);
        check("loadn_data", r_ld, 16'h00AA);
        check("loadn_npc", r_npc, 16'h0001);

        // start during the DONE cycle is dropped
        start = 1'b1;
        op = 3'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("done_start", busy, 0);

        // illegal op
        run(3'd6, 16'h0100, 16'h0, 16'h0);
        check("ill_cyc", cyc, 1);
        check("ill_flt", r_flt, 1);
        check("ill_req", reqc, 0);
        check("ill_npc", r_npc, 16'h0101);
        check("ill_we", r_we, 0);

        // LOAD timeout with ACK held low
        ack_low = 1'b1;
        run(3'd0, 16'h0050, 16'h0, 16'h0);
        check("tmo_req", reqc, 4);
        check("tmo_cyc", cyc, 5);
        check("tmo_flt", r_flt, 1);
        check("tmo_we", r_we, 0);
        check("tmo_npc", r_npc, 16'h0051);

        // reset in the middle of a stalled STOREI
        @(negedge clk);
        op = 3'd4; pc = 16'h0060; rx = 16'h0310; ry = 16'h7777;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wr0 = wrc;
        @(negedge clk);
        check("mid_req", {req, rw}, 2'b11);
        op = 3'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {busy, done, fault, ld_we, req, rw}, 0);
        check("mid_rst_dbg", dbg, 16'h0000);
        check("mid_rst_bus", {addr, din, npc}, 0);
        @(negedge clk);
        rst = 1'b0;
        ack_low = 1'b0;
        any_busy = 0;
        any_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            any_busy |= busy;
            any_done |= done;
        end
        check("post_rst_busy", any_busy, 0);
        check("post_rst_done", any_done, 0);
        check("post_rst_wr", wrc - wr0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ap9_lsu.md
# ap9_lsu

Parametrised multicycle load/store sequencer for the AP9 processor core. It replaces the fixed 16-bit, no-reset load/store handling with a reset-able engine. The engine supports direct, immediate and indirect addressing and a request/acknowledge RAM port that tolerates wait states, with an optional timeout. It sits between the instruction decoder (start/opcode/register operands) and the shared RAM bus.

## Interface
Parameters:
- DATA_W, 16, data word and register width
- ADDR_W, 16, RAM address width
- TIMEOUT, 0, maximum cycles to wait for wire_RAM_ACK per access; 0 disables the timeout

Ports:
- wire_clock  in  1  core clock; all state changes on its rising edge
- wire_reset  in  1  asynchronous, active-high reset
- wire_start  in  1  one-cycle request to execute bus_op; ignored while wire_busy=1
- bus_op  in  3  0 LOAD, 1 STORE, 2 LOADN, 3 LOADI, 4 STOREI, 5–7 illegal
- bus_pc  in  ADDR_W  address of the current instruction word
- bus_rx  in  DATA_W  Rx value (STORE data, STOREI pointer)
- bus_ry  in  DATA_W  Ry value (LOADI pointer, STOREI data)
- wire_busy  out  1  high from the cycle after an accepted start until the end of the done cycle
- wire_done  out  1  one-cycle completion pulse
- wire_load_we  out  1  high together with wire_done for LOAD, LOADN and LOADI
- bus_load_data  out  DATA_W  value to write into Rx; valid while wire_load_we=1
- bus_next_pc  out  ADDR_W  PC after the instruction; valid while wire_done=1
- wire_fault  out  1  high with wire_done on illegal op or timeout
- bus_RAM_ADDRESS  out  ADDR_W  RAM address
- wire_RW  out  1  1 = write, 0 = read
- bus_RAM_DATA_IN  out  DATA_W  write data to RAM
- bus_RAM_DATA_OUT  in  DATA_W  read data from RAM
- wire_RAM_REQ  out  1  access request
- wire_RAM_ACK  in  1  access complete; may be tied high for zero-wait RAM
- data_debug  out  16  current state code

## Operation
- States: IDLE, FETCH (read operand word at PC+1), MEM_RD, MEM_WR, DONE.
- Start is accepted only in IDLE. bus_op, bus_pc, bus_rx and bus_ry are latched at the accepting edge.
- LOAD: FETCH → MEM_RD at the fetched address → DONE. Rx ← read word; next_pc = PC+2.
- STORE: FETCH → MEM_WR, writing bus_rx at the fetched address → DONE. next_pc = PC+2.
- LOADN: FETCH → DONE. Rx ← fetched word; next_pc = PC+2.
- LOADI: MEM_RD at Ry → DONE. Rx ← read word; next_pc = PC+1.
- STOREI: MEM_WR at Rx with data Ry → DONE. next_pc = PC+1.
- Illegal op: IDLE → DONE with wire_fault=1. No RAM access; next_pc = PC+1.
- Address derivation: the low ADDR_W bits of a DATA_W value. If DATA_W < ADDR_W, the value is zero-extended.
- PC+1 and PC+2 wrap modulo 2^ADDR_W. For PC = all-ones, FETCH reads address 0.
- Timeout: if TIMEOUT > 0 and ACK has not arrived after TIMEOUT REQ cycles, REQ drops and the FSM goes to DONE with wire_fault=1. In that case no load write occurs (wire_load_we=0) and bus_next_pc = PC+1.
- data_debug codes: IDLE 0x0000, FETCH 0x0001, MEM_RD 0x0002, MEM_WR 0x0003, DONE 0x000F.

## Timing
- Reset (asynchronous, at any time, including mid-access): state IDLE. Every output is 0, including REQ, RW, done, busy, fault and data_debug. The timeout counter is cleared.
- REQ stays high in FETCH, MEM_RD and MEM_WR. Address, RW and write data are stable from REQ rise until the ACK edge.
- Each access completes at the first rising edge where REQ=1 and ACK=1. Read data is captured at that edge. REQ is deasserted or retargeted in the next cycle; back-to-back accesses produce no idle cycle.
- DONE lasts exactly one cycle, then the FSM returns to IDLE. A start in the DONE cycle is ignored; the earliest accepted start is in the following IDLE cycle.
- Latency with ACK tied high, counted from the accepting edge to the wire_done cycle: LOAD/STORE 3 cycles, LOADN/LOADI/STOREI 2, illegal 1. Each ACK wait cycle adds one.
- ACK while REQ=0 is ignored.

## Structure
- Package ap9_pkg holds the op enum, the state enum, the data_debug code constants and the op-to-next_pc-increment function.
- Sub-module ap9_mem_port handles REQ/ACK sequencing, read-data capture and the TIMEOUT counter. ap9_lsu holds the FSM and operand latches.

## Test plan
- LOAD, ACK tied, PC=0x0010, mem[0x0011]=0x0200, mem[0x0200]=0xBEEF → done in cycle 3, load_we=1, load_data=0xBEEF, next_pc=0x0012.
- STOREI, Rx=0x0300, Ry=0x1234, ACK delayed 2 cycles → single write to 0x0300 with data 0x1234, held stable through the wait; done in cycle 4; next_pc=PC+1.
- LOADN at PC=0xFFFF, mem[0x0000]=0x00AA → FETCH address 0x0000, load_data=0x00AA, next_pc=0x0001.
- Illegal op 6 → done and fault in cycle 1, REQ never asserted, next_pc=PC+1.
- TIMEOUT=4, ACK held low on LOAD → REQ high for 4 cycles, then done=1, fault=1, load_we=0.
- Reset asserted during a MEM_WR wait, plus a start pulse while busy → outputs zero immediately, FSM in IDLE, no done; the busy-time start has no effect.
